// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: instruction sequencing FSM, Moore datapath
// controls, ALU decoder and a retired-instruction counter.
module mc_control_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_en,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_control,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned ST_W = 4;

  localparam logic [ST_W-1:0] S_FETCH   = 4'd0;
  localparam logic [ST_W-1:0] S_DECODE  = 4'd1;
  localparam logic [ST_W-1:0] S_MEMADR  = 4'd2;
  localparam logic [ST_W-1:0] S_MEMRD   = 4'd3;
  localparam logic [ST_W-1:0] S_MEMWB   = 4'd4;
  localparam logic [ST_W-1:0] S_MEMWR   = 4'd5;
  localparam logic [ST_W-1:0] S_EXECUTE = 4'd6;
  localparam logic [ST_W-1:0] S_ALUWB   = 4'd7;
  localparam logic [ST_W-1:0] S_BRANCH  = 4'd8;
  localparam logic [ST_W-1:0] S_ADDIEX  = 4'd9;
  localparam logic [ST_W-1:0] S_ADDIWB  = 4'd10;
  localparam logic [ST_W-1:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire_c;
  logic             op_illegal_c;

  // State register and retired counter; reset wins over increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic; an instruction retires on its final edge back to FETCH.
  always_comb begin
    state_d      = S_FETCH;
    retire_c     = 1'b0;
    op_illegal_c = 1'b0;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d      = S_FETCH;
            op_illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      default:   state_d = S_FETCH;
    endcase
    retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;
  end

  logic       pc_write_c, branch_c, ir_write_c, reg_write_c, mem_write_c;
  logic [1:0] aluop_c;

  // Moore output decode plus ALU decoder; write strobes are held off in reset.
  always_comb begin
    iord        = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    branch_c    = 1'b0;
    reg_write_c = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    aluop_c     = 2'b00;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        alu_src_b  = 2'b01;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = op_illegal_c;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        aluop_c   = 2'b10;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop_c   = 2'b01;
        pc_src    = 2'b01;
        branch_c  = 1'b1;
      end
      S_ADDIWB:  reg_write_c = 1'b1;
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write_c = 1'b1;
      end
      default: ;
    endcase

    case (aluop_c)
      2'b01:   alu_control = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alu_control = 3'b110;
          6'b100100: alu_control = 3'b000;
          6'b100101: alu_control = 3'b001;
          6'b101010: alu_control = 3'b111;
          default:   alu_control = 3'b010;
        endcase
      end
      default: alu_control = 3'b010;
    endcase

    ir_write  = rst & ir_write_c;
    reg_write = rst & reg_write_c;
    mem_write = rst & mem_write_c;
    pc_en     = rst & (pc_write_c | (branch_c & zero));
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed instruction scenarios plus
// randomized instruction streams checked against an instruction-level model.
module tb_mc_control_fsm;

  localparam int unsigned CNT_W = 4;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       opcode, funct;
  logic             zero;
  logic             iord, mem_write, ir_write, pc_en, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]       alu_src_b, pc_src;
  logic [2:0]       alu_control;
  logic             illegal_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  int n_checks = 0;
  int n_fail   = 0;
  int retired_m = 0;

  mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_control(alu_control), .illegal_op(illegal_op), .state(state),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int classify(input logic [5:0] op);
    case (op)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return K_R;
      6'b000100: return K_BEQ;
      6'b001000: return K_ADDI;
      6'b000010: return K_J;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic int instr_len(input int kind);
    case (kind)
      K_LW:         return 5;
      K_SW, K_R, K_ADDI: return 4;
      K_BEQ, K_J:   return 3;
      default:      return 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_op(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected state code for cycle c of an instruction of the given kind.
  function automatic logic [3:0] phase_state(input int kind, input int c);
    logic [3:0] seq [5];
    if (c == 0) return 4'd0;
    if (c == 1) return 4'd1;
    case (kind)
      K_LW:   seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      K_SW:   seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
      K_R:    seq = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
      K_ADDI: seq = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
      K_BEQ:  seq = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0};
      K_J:    seq = '{4'd0, 4'd1, 4'd11, 4'd0, 4'd0};
      default: seq = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
    endcase
    return seq[c];
  endfunction

  function automatic logic [31:0] pack(input logic i_iord, i_mw, i_irw, i_pce, i_rw, i_rd, i_m2r, i_sa,
                                       input logic [1:0] i_sb, i_ps, input logic [2:0] i_ac,
                                       input logic i_ill, input logic [3:0] i_st);
    return {12'b0, i_iord, i_mw, i_irw, i_pce, i_rw, i_rd, i_m2r, i_sa, i_sb, i_ps, i_ac, i_ill, i_st};
  endfunction

  // Expected control word for cycle c of one instruction, from the instruction's role in that cycle.
  function automatic logic [31:0] exp_ctrl(input int kind, input int c, input logic [5:0] fn,
                                           input logic z, input logic rst_v);
    logic e_iord = 0, e_mw = 0, e_irw = 0, e_pce = 0, e_rw = 0, e_rd = 0, e_m2r = 0, e_sa = 0, e_ill = 0;
    logic [1:0] e_sb = 2'b00, e_ps = 2'b00;
    logic [2:0] e_ac = 3'b010;
    if (c == 0) begin
      e_irw = 1; e_pce = 1; e_sb = 2'b01;
    end else if (c == 1) begin
      e_sb = 2'b11; e_ill = (kind == K_ILL);
    end else begin
      case (kind)
        K_LW: if (c == 2) begin e_sa = 1; e_sb = 2'b10; end
              else if (c == 3) e_iord = 1;
              else begin e_rw = 1; e_m2r = 1; end
        K_SW: if (c == 2) begin e_sa = 1; e_sb = 2'b10; end
              else begin e_iord = 1; e_mw = 1; end
        K_R:  if (c == 2) begin e_sa = 1; e_ac = funct_op(fn); end
              else begin e_rw = 1; e_rd = 1; end
        K_ADDI: if (c == 2) begin e_sa = 1; e_sb = 2'b10; end
                else e_rw = 1;
        K_BEQ: begin e_sa = 1; e_ps = 2'b01; e_ac = 3'b110; e_pce = z; end
        K_J:   begin e_ps = 2'b10; e_pce = 1; end
        default: ;
      endcase
    end
    if (!rst_v) begin
      e_irw = 0; e_pce = 0; e_rw = 0; e_mw = 0;
    end
    return pack(e_iord, e_mw, e_irw, e_pce, e_rw, e_rd, e_m2r, e_sa, e_sb, e_ps, e_ac, e_ill,
                phase_state(kind, c));
  endfunction

  function automatic logic [31:0] obs_ctrl();
    return pack(iord, mem_write, ir_write, pc_en, reg_write, reg_dst, mem_to_reg, alu_src_a,
                alu_src_b, pc_src, alu_control, illegal_op, state);
  endfunction

  // Runs one instruction from FETCH; abort_at >= 0 pulls rst low during that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode, input int abort_at);
    int kind = classify(op);
    int n = instr_len(kind);
    opcode = op;
    funct  = fn;
    for (int c = 0; c < n; c++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (c == abort_at) rst = 1'b0;
      #1;
      check_eq("ctrl", obs_ctrl(), exp_ctrl(kind, c, fn, zero, rst));
      check_eq("retired", 32'(retired), 32'(retired_m));
      @(posedge clk); #1;
      if (c == abort_at) begin
        retired_m = 0;
        check_eq("abort_state", 32'(state), 32'd0);
        check_eq("abort_retired", 32'(retired), 32'd0);
        check_eq("abort_strobes", 32'({ir_write, pc_en, reg_write, mem_write}), 32'd0);
        rst = 1'b1;
        return;
      end
    end
    if (kind != K_ILL) retired_m = (retired_m + 1) % (1 << CNT_W);
    check_eq("end_state", 32'(state), 32'd0);
    check_eq("end_retired", 32'(retired), 32'(retired_m));
  endtask

  logic [5:0] legal_ops [6];
  logic [5:0] legal_fns [5];

  initial begin
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    legal_fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst = 1'b0; opcode = 6'b111111; funct = 6'b0; zero = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_retired", 32'(retired), 32'd0);
    check_eq("rst_strobes", 32'({ir_write, pc_en, reg_write, mem_write}), 32'd0);
    check_eq("rst_ctrl", obs_ctrl(), exp_ctrl(K_LW, 0, 6'b0, 1'b0, 1'b0));
    rst = 1'b1;
    retired_m = 0;

    run_instr(6'b100011, 6'b000000, 2, -1);  // lw
    run_instr(6'b000000, 6'b101010, 2, -1);  // slt
    run_instr(6'b101011, 6'b000000, 2, -1);  // sw
    run_instr(6'b000100, 6'b000000, 1, -1);  // beq taken
    run_instr(6'b000100, 6'b000000, 0, -1);  // beq not taken
    run_instr(6'b000010, 6'b000000, 2, -1);  // j
    run_instr(6'b111111, 6'b000000, 2, -1);  // illegal
    run_instr(6'b000000, 6'b111111, 2, -1);  // R-type with unknown funct
    run_instr(6'b100011, 6'b000000, 2, 3);   // reset during MEMRD

    for (int i = 0; i < 16; i++) run_instr(6'b001000, 6'b000000, 2, -1);
    check_eq("wrap_retired", 32'(retired), 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] op, fn;
      int sel = $urandom_range(0, 7);
      op = (sel < 6) ? legal_ops[sel] : 6'($urandom);
      fn = ($urandom_range(0, 1) == 1) ? legal_fns[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(op, fn, 2, ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS main controller. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath enables and muxes, including reg_write, reg_dst and mem_to_reg, which select the register-file write port (W1/D1 path). It sits directly upstream of the register file.
- Includes the ALU decoder and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-low (rst==0 resets at the next clk edge)
- opcode  input  6  instr[31:26] from instruction register; stable from DECODE onward
- funct  input  6  instr[5:0]
- zero  input  1  ALU zero flag
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- mem_write  output  1  data memory write enable
- ir_write  output  1  instruction register load
- pc_en  output  1  PC load = pc_write | (branch & zero)
- reg_write  output  1  register file write enable
- reg_dst  output  1  write address select: 0=rt, 1=rd
- mem_to_reg  output  1  write data select: 0=ALUOut, 1=MDR
- alu_src_a  output  1  ALU A select: 0=PC, 1=A reg
- alu_src_b  output  2  ALU B select: 00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
- pc_src  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- alu_control  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode
- state  output  4  current state, for debug
- retired  output  CNT_W  count of completed instructions

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 go to FETCH on the next edge.
- Reset: on a clk edge with rst==0, state<=FETCH and retired<=0.
- While rst==0, ir_write, pc_en, reg_write and mem_write are forced to 0. All other outputs follow the state decode.
- A reset mid-instruction aborts the instruction with no further writes; it is not counted.
- Transitions:
  - FETCH -> DECODE.
  - DECODE dispatches on opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH with illegal_op=1 for that cycle
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD -> MEMWB; EXECUTE -> ALUWB; ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP -> FETCH.
- Moore outputs; any signal not listed for a state is 0:
  - FETCH: ir_write=1, pc_write=1, alu_src_b=01, aluop=00.
  - DECODE: alu_src_b=11, aluop=00.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - MEMWR: iord=1, mem_write=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, aluop=10.
  - ALUWB: reg_write=1, reg_dst=1.
  - BRANCH: alu_src_a=1, aluop=01, pc_src=01, branch=1.
  - ADDIWB: reg_write=1, reg_dst=0.
  - JUMP: pc_src=10, pc_write=1.
- pc_en is combinational and uses zero only in BRANCH.
- ALU decoder:
  - aluop=00 -> 010.
  - aluop=01 -> 110.
  - aluop=10 decodes funct: 100000 add->010, 100010 sub->110, 100100 and->000, 100101 or->001, 101010 slt->111. Any other funct -> 010 (the write still occurs).
- Cycles per instruction: lw 5; sw, R-type and addi 4; beq and j 3; illegal opcode 2 (no write, not counted).
- retired increments by 1 on each edge leaving MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP toward FETCH. It wraps from all-ones to 0. Reset has priority over increment.

Test Plan:
- Reset: hold rst=0 for 2 edges, release -> state=0, retired=0, and ir_write, pc_en, reg_write, mem_write all 0 while rst=0. First active cycle shows ir_write=1, pc_en=1.
- lw (opcode 100011) -> states 0,1,2,3,4,0. In state 4: reg_write=1, mem_to_reg=1, reg_dst=0. retired=1 after the 5th edge.
- R-type slt (opcode 000000, funct 101010) -> EXECUTE with alu_control=111, then ALUWB with reg_write=1, reg_dst=1. sw (opcode 101011) -> MEMWR with mem_write=1 and iord=1, reg_write never 1.
- beq (opcode 000100): with zero=1, pc_en=1 and pc_src=01 in BRANCH; with zero=0, pc_en=0. j (opcode 000010) -> JUMP with pc_src=10, pc_en=1. Each takes 3 cycles.
- Illegal opcode 111111 -> illegal_op=1 for one cycle in DECODE, back to FETCH, retired unchanged. rst=0 during MEMRD -> FETCH next edge, no reg_write, retired=0.
- Wrap: with CNT_W=4, run 16 addi instructions (opcode 001000) -> retired returns to 0; ADDIWB asserts reg_write=1 with reg_dst=0.
